reg_bank: RTL and testbench

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank_if.sv | 30 +++
 rtl/reg_bank.sv | 117 +++++++++++
 tb/tb_reg_bank.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_if
// Description : Write-strobe and dual read-port bundle for reg_bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_bank_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] rd_addr_a;
  logic [2:0] rd_addr_b;
  logic [7:0] rd_data_a;
  logic [7:0] rd_data_b;
  logic       wr_ack;
  logic       busy;
  logic       err;
  logic [7:0] wr_count;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, wr_ack, busy, err, wr_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, wr_ack, busy, err, wr_count
  );
endinterface
`default_nettype wire

// File: rtl/reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank
// Description : 8x8 register bank, one write per wr_en rising level, with
//               strobe-length supervision and two registered read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank #(
  parameter int HOLD_MAX = 4
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  reg_bank_if.slave   bus
);

  localparam int                 c_CNT_W    = $clog2(HOLD_MAX + 2);
  localparam logic [c_CNT_W-1:0] c_HOLD_LIM = c_CNT_W'(HOLD_MAX);
  localparam logic [c_CNT_W-1:0] c_HOLD_SAT = c_CNT_W'(HOLD_MAX + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 w_wr;
  logic                 w_hold_inc;
  logic                 w_hold_clr;
  logic                 w_err_set;

  logic [7:0]           r_regs [8];
  logic [c_CNT_W-1:0]   r_hold_cnt;
  logic [7:0]           r_wr_count;
  logic [7:0]           r_rd_data_a;
  logic [7:0]           r_rd_data_b;
  logic                 r_wr_ack;
  logic                 r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Only the IDLE->HOLD transition writes; a held level is supervised, not re-written.
  always_comb begin
    w_next_state = r_state;
    w_wr         = 1'b0;
    w_hold_inc   = 1'b0;
    w_hold_clr   = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.wr_en) begin
          w_wr         = 1'b1;
          w_next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.wr_en) begin
          w_hold_inc = 1'b1;
          w_err_set  = (r_hold_cnt == c_HOLD_LIM);
        end else begin
          w_hold_clr   = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs      <= '{default: '0};
      r_hold_cnt  <= '0;
      r_wr_count  <= '0;
      r_rd_data_a <= '0;
      r_rd_data_b <= '0;
      r_wr_ack    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_wr_ack <= w_wr;

      if (w_wr) begin
        r_regs[bus.wr_addr] <= bus.wr_data;
        r_wr_count          <= r_wr_count + 8'd1;
        r_hold_cnt          <= c_CNT_W'(1);
      end else if (w_hold_clr) begin
        r_hold_cnt <= '0;
      end else if (w_hold_inc && (r_hold_cnt != c_HOLD_SAT)) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end

      if (w_err_set) begin
        r_err <= 1'b1;
      end

      // Same-edge write to the addressed register is forwarded to each port.
      r_rd_data_a <= (w_wr && (bus.wr_addr == bus.rd_addr_a)) ? bus.wr_data
                                                               : r_regs[bus.rd_addr_a];
      r_rd_data_b <= (w_wr && (bus.wr_addr == bus.rd_addr_b)) ? bus.wr_data
                                                               : r_regs[bus.rd_addr_b];
    end
  end

  assign bus.rd_data_a = r_rd_data_a;
  assign bus.rd_data_b = r_rd_data_b;
  assign bus.wr_ack    = r_wr_ack;
  assign bus.busy      = (r_state == ST_HOLD);
  assign bus.err       = r_err;
  assign bus.wr_count  = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank
// Description : Directed scoreboard bench for reg_bank (ack and read queues).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_bank_if bus();

  reg_bank #(.HOLD_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_errs   = 0;
  int          ack_seen = 0;
  logic [7:0]  ack_q [$];
  logic [15:0] rd_q  [$];
  logic        rd_chk   = 1'b0;
  logic        rd_chk_d = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " rd_data_a"}, {24'd0, bus.rd_data_a}, 32'd0);
    chk({tag, " rd_data_b"}, {24'd0, bus.rd_data_b}, 32'd0);
    chk({tag, " wr_ack"},    {31'd0, bus.wr_ack},    32'd0);
    chk({tag, " busy"},      {31'd0, bus.busy},      32'd0);
    chk({tag, " err"},       {31'd0, bus.err},       32'd0);
    chk({tag, " wr_count"},  {24'd0, bus.wr_count},  32'd0);
  endtask

  task automatic read_ports(input logic [2:0] a, input logic [2:0] b,
                            input logic [7:0] ea, input logic [7:0] eb);
    bus.rd_addr_a = a;
    bus.rd_addr_b = b;
    rd_q.push_back({ea, eb});
    rd_chk = 1'b1;
    step();
    rd_chk = 1'b0;
  endtask

  // rd_chk acts as the read-valid, delayed by the one-cycle read latency.
  always @(posedge clk) rd_chk_d <= rd_chk;

  always @(negedge clk) begin
    if (rst_n && bus.wr_ack) begin
      ack_seen++;
      if (ack_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL spurious wr_ack: got pulse expected none, wr_count=%0h at %0t",
                 bus.wr_count, $time);
      end else begin
        chk("wr_count at ack", {24'd0, bus.wr_count}, {24'd0, ack_q.pop_front()});
      end
    end
    if (rd_chk_d) begin
      logic [15:0] e;
      if (rd_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL read queue: got read strobe expected queued entry at %0t", $time);
      end else begin
        e = rd_q.pop_front();
        chk("rd_data_a", {24'd0, bus.rd_data_a}, {24'd0, e[15:8]});
        chk("rd_data_b", {24'd0, bus.rd_data_b}, {24'd0, e[7:0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ack_base;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_addr_a = '0;
    bus.rd_addr_b = '0;

    #12;
    chk_all_zero("reset");
    step();
    rst_n = 1'b1;
    step();

    // Three-cycle strobe: one write, busy for three cycles.
    bus.wr_en = 1'b1; bus.wr_addr = 3'd5; bus.wr_data = 8'hA7;
    ack_q.push_back(8'd1);
    step(); chk("busy c1", {31'd0, bus.busy}, 32'd1);
    step(); chk("busy c2", {31'd0, bus.busy}, 32'd1);
    step(); chk("busy c3", {31'd0, bus.busy}, 32'd1);
    bus.wr_en = 1'b0;
    step(); chk("busy after", {31'd0, bus.busy}, 32'd0);
    chk("err strobe3", {31'd0, bus.err}, 32'd0);
    chk("wr_count strobe3", {24'd0, bus.wr_count}, 32'd1);
    read_ports(3'd5, 3'd0, 8'hA7, 8'h00);

    // Data change while held is ignored.
    bus.wr_en = 1'b1; bus.wr_data = 8'hA7;
    ack_q.push_back(8'd2);
    step(); bus.wr_data = 8'h11;
    step(); bus.wr_en = 1'b0;
    step();
    chk("wr_count held data", {24'd0, bus.wr_count}, 32'd2);
    read_ports(3'd5, 3'd5, 8'hA7, 8'hA7);

    // Five sampled-high edges trip err on the fifth; sticky, non-blocking.
    bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 8'h42;
    ack_q.push_back(8'd3);
    step(); chk("err e1", {31'd0, bus.err}, 32'd0);
    step(); step(); step();
    chk("err e4", {31'd0, bus.err}, 32'd0);
    step(); chk("err e5", {31'd0, bus.err}, 32'd1);
    bus.wr_en = 1'b0;
    step(); chk("err after drop", {31'd0, bus.err}, 32'd1);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 8'h99;
    ack_q.push_back(8'd4);
    step(); bus.wr_en = 1'b0;
    step();
    chk("err after write", {31'd0, bus.err}, 32'd1);
    chk("wr_count after err", {24'd0, bus.wr_count}, 32'd4);
    read_ports(3'd3, 3'd1, 8'h99, 8'h42);

    // Write-through bypass on both ports.
    bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 8'h3C;
    bus.rd_addr_a = 3'd2; bus.rd_addr_b = 3'd2;
    rd_q.push_back({8'h3C, 8'h3C});
    ack_q.push_back(8'd5);
    rd_chk = 1'b1;
    step();
    bus.wr_en = 1'b0; rd_chk = 1'b0;
    step();

    // Asynchronous reset clears err.
    #1 rst_n = 1'b0;
    #1 chk_all_zero("reset2");
    rst_n = 1'b1;

    // 256 strobes wrap the counter back to zero.
    ack_base = ack_seen;
    for (int i = 0; i < 256; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = i[2:0];
      bus.wr_data = i[7:0];
      ack_q.push_back(8'((i + 1) % 256));
      step();
      bus.wr_en = 1'b0;
      step();
    end
    chk("wr_count wrap", {24'd0, bus.wr_count}, 32'd0);
    chk("ack pulses 256", ack_seen - ack_base, 32'd256);
    read_ports(3'd0, 3'd7, 8'hF8, 8'hFF);
    read_ports(3'd7, 3'd7, 8'hFF, 8'hFF);

    // Reset mid-HOLD, then strobe kept high is a new write.
    bus.wr_en = 1'b1; bus.wr_addr = 3'd6; bus.wr_data = 8'h77;
    ack_q.push_back(8'd1);
    step(); step();
    chk("busy pre-reset", {31'd0, bus.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid-hold reset");
    rst_n = 1'b1;
    ack_q.push_back(8'd1);
    step();
    chk("busy post-reset", {31'd0, bus.busy}, 32'd1);
    chk("wr_count post-reset", {24'd0, bus.wr_count}, 32'd1);
    bus.wr_en = 1'b0;
    step();
    chk("busy idle", {31'd0, bus.busy}, 32'd0);
    read_ports(3'd6, 3'd0, 8'h77, 8'h00);

    step(); step();
    chk("ack queue drained", ack_q.size(), 32'd0);
    chk("read queue drained", rd_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
